// File: rtl/dmem_responder.sv
// Data-memory responder for the M stage: models access latency, stalls the core via busy,
// and returns byte/halfword-aligned, sign- or zero-extended load data.
module dmem_responder #(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  input  logic             we,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] addr,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             ready,
  output logic [WIDTH-1:0] rdata,
  output logic             err
);
  localparam int AW = $clog2(DEPTH);
  localparam int NB = WIDTH / 8;
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t          state;
  logic [CW-1:0]   count;
  logic            we_q;
  logic [2:0]      funct3_q;
  logic [AW+1:0]   addr_q;
  logic [WIDTH-1:0] wdata_q;

  logic [WIDTH-1:0] mem [DEPTH];

  logic             idle;
  logic             bad_live;
  logic             op_we;
  logic             op_bad;
  logic [2:0]       op_f3;
  logic [AW+1:0]    op_addr;
  logic [WIDTH-1:0] op_wdata;
  logic [AW-1:0]    idx;
  logic [WIDTH-1:0] word;
  logic [7:0]       byte_sel;
  logic [15:0]      half_sel;
  logic [WIDTH-1:0] load_val;
  logic             enter_done;
  logic [NB-1:0]    lane_en;
  logic [7:0]       lane_data [NB];
  logic             unused_addr;

  assign unused_addr = ^addr[WIDTH-1:AW+2];
  assign busy = req & ~ready;
  assign idle = (state == IDLE);

  always_comb begin
    bad_live = 1'b0;
    case (funct3)
      3'b000:         bad_live = 1'b0;
      3'b001:         bad_live = addr[0];
      3'b010:         bad_live = |addr[1:0];
      3'b100, 3'b101: bad_live = we | (funct3[0] & addr[0]);
      default:        bad_live = 1'b1;
    endcase
  end

  // The live request drives the datapath in IDLE so error and zero-latency ops finish on the accepting edge.
  assign op_we    = idle ? we : we_q;
  assign op_f3    = idle ? funct3 : funct3_q;
  assign op_addr  = idle ? addr[AW+1:0] : addr_q;
  assign op_wdata = idle ? wdata : wdata_q;
  assign op_bad   = idle & bad_live;

  assign enter_done = (idle && req && (bad_live || (LATENCY == 0))) ||
                      ((state == WAIT) && (count == '0));

  assign idx      = op_addr[AW+1:2];
  assign word     = mem[idx];
  assign byte_sel = 8'(word >> {op_addr[1:0], 3'b000});
  assign half_sel = 16'(word >> {op_addr[1], 4'b0000});

  always_comb begin
    load_val = word;
    case (op_f3)
      3'b000:  load_val = {{(WIDTH-8){byte_sel[7]}}, byte_sel};
      3'b100:  load_val = {{(WIDTH-8){1'b0}}, byte_sel};
      3'b001:  load_val = {{(WIDTH-16){half_sel[15]}}, half_sel};
      3'b101:  load_val = {{(WIDTH-16){1'b0}}, half_sel};
      default: load_val = word;
    endcase
  end

  // Store lanes: bytes replicate wdata[7:0], halves replicate wdata[15:0], words pass straight through.
  for (genvar gi = 0; gi < NB; gi++) begin : g_lane
    localparam logic [1:0] LANE = 2'(gi);
    assign lane_en[gi] = (op_f3[1:0] == 2'b10) ||
                         ((op_f3[1:0] == 2'b01) && (op_addr[1] == LANE[1])) ||
                         ((op_f3[1:0] == 2'b00) && (op_addr[1:0] == LANE));
    assign lane_data[gi] = (op_f3[1:0] == 2'b10) ? op_wdata[8*gi +: 8] :
                           (op_f3[1:0] == 2'b01) ? op_wdata[8*(gi%2) +: 8] :
                                                   op_wdata[7:0];
  end

  always_ff @(posedge clk) begin
    if (!rst && enter_done && op_we && !op_bad) begin
      for (int i = 0; i < NB; i++) begin
        if (lane_en[i]) mem[idx][8*i +: 8] <= lane_data[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      count <= '0;
      ready <= 1'b0;
      err   <= 1'b0;
      rdata <= '0;
    end else begin
      ready <= 1'b0;
      err   <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            we_q     <= we;
            funct3_q <= funct3;
            addr_q   <= addr[AW+1:0];
            wdata_q  <= wdata;
            if (bad_live || (LATENCY == 0)) begin
              state <= DONE;
            end else begin
              count <= CW'(LATENCY - 1);
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (count == '0) state <= DONE;
          else             count <= count - 1'b1;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
      if (enter_done) begin
        ready <= 1'b1;
        err   <= op_bad;
        if (!op_we && !op_bad) rdata <= load_val;
      end
    end
  end
endmodule
